cpu_register_bank: RTL
======================

Name: cpu_register_bank

Overview:
Parametrised architectural register bank for the softcore: A, X, Y, SP, PC, PS.
- Adds PC auto-increment, byte-wise PC loads, SP push/pop with wrap detection, and masked per-flag PS writes.
- Sits between the decode/control FSM and the ALU/memory interface.
- Provides the current stack address for bus cycles.

Parameters:
DATA_W, 8, width of A/X/Y/SP/PS and of data_in/flags_in
ADDR_W, 16, width of PC and stack_addr; must be 2*DATA_W
PC_RESET, 16'h1000, PC value after reset
SP_RESET, 8'hFF, SP value after reset
PS_RESET, 8'h34, PS value after reset
PS_ONE_MASK, 8'h20, PS bits that always read 1 regardless of writes
STACK_PAGE, 8'h01, high byte of stack_addr

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
we_a / we_x / we_y  in  1 each  load data_in into A / X / Y
we_sp  in  1  load data_in into SP
sp_push  in  1  SP <= SP-1
sp_pop  in  1  SP <= SP+1
we_pc  in  1  load pc_in into PC
we_pcl / we_pch  in  1 each  load data_in into PC low / high byte
pc_inc  in  1  PC <= PC + pc_step
pc_step  in  2  increment amount, 0..3
we_ps  in  1  masked flag write
flag_mask  in  DATA_W  PS bits updated when we_ps=1
data_in  in  DATA_W  data bus for register loads
flags_in  in  DATA_W  new flag values
pc_in  in  ADDR_W  full PC load value
A, X, Y, SP, PS  out  DATA_W  registered architectural state
PC  out  ADDR_W  registered program counter
stack_addr  out  ADDR_W  combinational {STACK_PAGE, SP}
sp_wrap  out  1  registered one-cycle pulse on SP wrap

Behaviour:
- Reset (async, active-high):
  - A=X=Y=0, SP=SP_RESET, PC=PC_RESET, PS=PS_RESET|PS_ONE_MASK, sp_wrap=0.
  - Reset mid-operation discards all pending writes in that cycle.
- Write timing: all writes take effect on the rising clk edge; new value is visible on outputs the following cycle (1-cycle latency). With no enables asserted, registers hold.
- A/X/Y: independent. Several may load the same data_in in one cycle.
- SP priority, highest first:
  1. we_sp
  2. sp_push xor sp_pop
  - push and pop together with no we_sp: SP holds, sp_wrap=0.
  - Arithmetic is modulo 2^DATA_W.
- sp_wrap: pulses 1 for one cycle after either of:
  - push with SP=0x00 (result 0xFF)
  - pop with SP=0xFF (result 0x00)
  - we_sp never sets sp_wrap.
- PC priority, highest first:
  1. we_pc
  2. byte loads (we_pcl and/or we_pch, both allowed in the same cycle; unwritten byte holds)
  3. pc_inc
  - Increment is modulo 2^ADDR_W, so 0xFFFF+1 = 0x0000. pc_step=0 with pc_inc holds PC.
- PS: when we_ps=1, PS <= ((PS & ~flag_mask) | (flags_in & flag_mask)) | PS_ONE_MASK. flag_mask=0 is a no-op.
- stack_addr: combinational from the SP register; changes only after the SP edge.

Optional Feature:
Macro CPU_REG_SHADOW_EN.
- Defined:
  - Adds inputs ctx_save and ctx_restore (1 bit each).
  - ctx_save copies A, X, Y, PS into shadow registers (cleared to 0 / PS_RESET on reset).
  - ctx_restore loads A, X, Y, PS from the shadows and overrides we_a/we_x/we_y/we_ps that cycle.
  - save and restore in the same cycle: restore wins for the architectural registers; the shadows still capture the pre-edge values.
- Undefined: no ports, no shadow storage, behaviour exactly as above.

Decomposition:
- Package cpu_reg_pkg holds:
  - default reset constants (PC_RESET, SP_RESET, PS_RESET)
  - PS bit indices: C=0, Z=1, I=2, D=3, B=4, U=5, V=6, N=7
  - STACK_PAGE
- One natural sub-module, cpu_stack_ptr: SP register, push/pop arithmetic, we_sp priority, sp_wrap pulse.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> immediately A=0, SP=0xFF, PC=0x1000, PS=0x34, sp_wrap=0.
- PC sources: we_pcl=1, data_in=0x34 -> PC=0x1034; then we_pch=1, data_in=0x12 -> 0x1234; then we_pc=1, pc_in=0xFFFE plus pc_inc, pc_step=3 -> PC=0xFFFE (full load wins); then pc_inc, pc_step=3 -> PC=0x0001.
- Stack: we_sp with 0x00, then sp_push -> SP=0xFF, stack_addr=0x01FF, sp_wrap=1 for exactly one cycle; push+pop same cycle -> SP unchanged.
- Flags: PS=0x34, we_ps=1, flag_mask=0x83, flags_in=0xFF -> PS=0xB7; flags_in=0x00, flag_mask=0x20 -> PS stays 0xB7 (U bit forced).
- A/X/Y: we_a=we_x=1, data_in=0x5A -> A=X=0x5A, Y unchanged.
- Shadow (CPU_REG_SHADOW_EN): A=0x11, ctx_save; then load A=0x22; then ctx_restore together with we_a, data_in=0x33 -> A=0x11.

Source files
------------

// File: rtl/cpu_reg_pkg.sv
// Shared constants for the softcore register bank: reset defaults, stack page, PS flag bit positions.
package cpu_reg_pkg;

   localparam logic [15:0] DEF_PC_RESET    = 16'h1000;
   localparam logic [7:0]  DEF_SP_RESET    = 8'hFF;
   localparam logic [7:0]  DEF_PS_RESET    = 8'h34;
   localparam logic [7:0]  DEF_PS_ONE_MASK = 8'h20;
   localparam logic [7:0]  DEF_STACK_PAGE  = 8'h01;

   typedef enum logic [2:0] {
      PS_C = 3'd0,
      PS_Z = 3'd1,
      PS_I = 3'd2,
      PS_D = 3'd3,
      PS_B = 3'd4,
      PS_U = 3'd5,
      PS_V = 3'd6,
      PS_N = 3'd7
   } ps_bit_e;

endpackage

// File: rtl/cpu_stack_ptr.sv
// Stack pointer: direct load has priority over push/pop; sp_wrap pulses for one cycle when push/pop wraps.
module cpu_stack_ptr
   import cpu_reg_pkg::*;
#(
   parameter int unsigned          DATA_W   = 8,
   parameter logic [DATA_W-1:0]    SP_RESET = DEF_SP_RESET
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_sp_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] sp_o,
   output logic              wrap_o
);

   logic [DATA_W-1:0] sp_q, sp_d;
   logic              wrap_q, wrap_d;

   always_comb begin
      sp_d   = sp_q;
      wrap_d = 1'b0;
      if (we_sp_i) begin
         sp_d = data_i;
      end else if (push_i && !pop_i) begin
         sp_d   = sp_q - 1'b1;
         wrap_d = (sp_q == '0);
      end else if (pop_i && !push_i) begin
         sp_d   = sp_q + 1'b1;
         wrap_d = (sp_q == '1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sp_q   <= SP_RESET;
         wrap_q <= 1'b0;
      end else begin
         sp_q   <= sp_d;
         wrap_q <= wrap_d;
      end
   end

   assign sp_o   = sp_q;
   assign wrap_o = wrap_q;

endmodule

// File: rtl/cpu_register_bank.sv
// Architectural register bank (A, X, Y, SP, PC, PS) with PC stepping, byte PC loads and masked flag writes.
// Optional context shadow registers are enabled with `define CPU_REG_SHADOW_EN.
module cpu_register_bank
   import cpu_reg_pkg::*;
#(
   parameter int unsigned          DATA_W      = 8,
   parameter int unsigned          ADDR_W      = 16,
   parameter logic [ADDR_W-1:0]    PC_RESET    = DEF_PC_RESET,
   parameter logic [DATA_W-1:0]    SP_RESET    = DEF_SP_RESET,
   parameter logic [DATA_W-1:0]    PS_RESET    = DEF_PS_RESET,
   parameter logic [DATA_W-1:0]    PS_ONE_MASK = DEF_PS_ONE_MASK,
   parameter logic [DATA_W-1:0]    STACK_PAGE  = DEF_STACK_PAGE
) (
   input  logic              clk,
   input  logic              reset,
`ifdef CPU_REG_SHADOW_EN
   input  logic              ctx_save,
   input  logic              ctx_restore,
`endif
   input  logic              we_a,
   input  logic              we_x,
   input  logic              we_y,
   input  logic              we_sp,
   input  logic              sp_push,
   input  logic              sp_pop,
   input  logic              we_pc,
   input  logic              we_pcl,
   input  logic              we_pch,
   input  logic              pc_inc,
   input  logic [1:0]        pc_step,
   input  logic              we_ps,
   input  logic [DATA_W-1:0] flag_mask,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] flags_in,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] X,
   output logic [DATA_W-1:0] Y,
   output logic [DATA_W-1:0] SP,
   output logic [DATA_W-1:0] PS,
   output logic [ADDR_W-1:0] PC,
   output logic [ADDR_W-1:0] stack_addr,
   output logic              sp_wrap
);

   logic [DATA_W-1:0] a_q, a_d, x_q, x_d, y_q, y_d, ps_q, ps_d;
   logic [DATA_W-1:0] ld_a, ld_x, ld_y, ld_ps;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] sp;

   cpu_stack_ptr #(
      .DATA_W   (DATA_W),
      .SP_RESET (SP_RESET)
   ) u_stack_ptr (
      .clk_i   (clk),
      .rst_i   (reset),
      .we_sp_i (we_sp),
      .push_i  (sp_push),
      .pop_i   (sp_pop),
      .data_i  (data_in),
      .sp_o    (sp),
      .wrap_o  (sp_wrap)
   );

   always_comb begin
      ld_a  = we_a ? data_in : a_q;
      ld_x  = we_x ? data_in : x_q;
      ld_y  = we_y ? data_in : y_q;
      ld_ps = ps_q;
      if (we_ps) begin
         ld_ps = (ps_q & ~flag_mask) | (flags_in & flag_mask) | PS_ONE_MASK;
      end
   end

`ifdef CPU_REG_SHADOW_EN
   logic [DATA_W-1:0] sh_a_q, sh_x_q, sh_y_q, sh_ps_q;

   // Shadows always sample the pre-edge state, so save+restore swaps cleanly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_a_q  <= '0;
         sh_x_q  <= '0;
         sh_y_q  <= '0;
         sh_ps_q <= PS_RESET;
      end else if (ctx_save) begin
         sh_a_q  <= a_q;
         sh_x_q  <= x_q;
         sh_y_q  <= y_q;
         sh_ps_q <= ps_q;
      end
   end

   assign a_d  = ctx_restore ? sh_a_q : ld_a;
   assign x_d  = ctx_restore ? sh_x_q : ld_x;
   assign y_d  = ctx_restore ? sh_y_q : ld_y;
   assign ps_d = ctx_restore ? (sh_ps_q | PS_ONE_MASK) : ld_ps;
`else
   assign a_d  = ld_a;
   assign x_d  = ld_x;
   assign y_d  = ld_y;
   assign ps_d = ld_ps;
`endif

   always_comb begin
      pc_d = pc_q;
      if (we_pc) begin
         pc_d = pc_in;
      end else if (we_pcl || we_pch) begin
         if (we_pcl) pc_d[DATA_W-1:0]      = data_in;
         if (we_pch) pc_d[ADDR_W-1:DATA_W] = data_in;
      end else if (pc_inc) begin
         pc_d = pc_q + ADDR_W'(pc_step);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q  <= '0;
         x_q  <= '0;
         y_q  <= '0;
         ps_q <= PS_RESET | PS_ONE_MASK;
         pc_q <= PC_RESET;
      end else begin
         a_q  <= a_d;
         x_q  <= x_d;
         y_q  <= y_d;
         ps_q <= ps_d;
         pc_q <= pc_d;
      end
   end

   assign A          = a_q;
   assign X          = x_q;
   assign Y          = y_q;
   assign SP         = sp;
   assign PS         = ps_q;
   assign PC         = pc_q;
   assign stack_addr = {STACK_PAGE, sp};

endmodule
